// File: rtl/fad_pipe_array.sv
// fad_pipe_array: pipelined add/subtract, one SEG_WIDTH ripple segment per stage.
// Carries are registered between stages; a global valid/ready enable stalls the whole pipe.
module fad_pipe_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEG_WIDTH  = 8,
    parameter int unsigned NUM_SEG    = DATA_WIDTH / SEG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  ovf
);

    logic                  adv;
    logic [DATA_WIDTH-1:0] beff;

    logic                  v_q   [NUM_SEG];
    logic                  c_q   [NUM_SEG];
    logic [DATA_WIDTH-1:0] acc_q [NUM_SEG];
    logic [DATA_WIDTH-1:0] b_q   [NUM_SEG];
    logic                  ovf_q;

    logic [DATA_WIDTH-1:0] acc_d [NUM_SEG];
    logic                  c_d   [NUM_SEG];
    logic                  ovf_d;

    assign adv      = ~v_q[NUM_SEG-1] | out_ready;
    assign in_ready = adv;
    assign beff     = sub ? ~b : b;

    // acc holds finished sum segments below stage k and untouched operand-A segments above,
    // so a single word per stage covers both the skew and deskew registers.
    always_comb begin : p_seg
        logic [DATA_WIDTH-1:0] x;
        logic [DATA_WIDTH-1:0] y;
        logic                  ci;
        logic [SEG_WIDTH:0]    s;
        x     = '0;
        y     = '0;
        ci    = 1'b0;
        s     = '0;
        ovf_d = 1'b0;
        for (int unsigned k = 0; k < NUM_SEG; k++) begin
            x  = (k == 0) ? a    : acc_q[(k == 0) ? 0 : k - 1];
            y  = (k == 0) ? beff : b_q[(k == 0) ? 0 : k - 1];
            ci = (k == 0) ? cin  : c_q[(k == 0) ? 0 : k - 1];
            s  = {1'b0, x[k*SEG_WIDTH +: SEG_WIDTH]} + {1'b0, y[k*SEG_WIDTH +: SEG_WIDTH]}
               + {{SEG_WIDTH{1'b0}}, ci};
            acc_d[k] = x;
            acc_d[k][k*SEG_WIDTH +: SEG_WIDTH] = s[SEG_WIDTH-1:0];
            c_d[k]   = s[SEG_WIDTH];
            if (k == NUM_SEG - 1) begin
                ovf_d = (x[DATA_WIDTH-1] == y[DATA_WIDTH-1]) & (s[SEG_WIDTH-1] != x[DATA_WIDTH-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_SEG; k++) begin
                v_q[k]   <= 1'b0;
                c_q[k]   <= 1'b0;
                acc_q[k] <= '0;
                b_q[k]   <= '0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k < NUM_SEG; k++) begin
                v_q[k]   <= (k == 0) ? in_valid : v_q[(k == 0) ? 0 : k - 1];
                b_q[k]   <= (k == 0) ? beff     : b_q[(k == 0) ? 0 : k - 1];
                c_q[k]   <= c_d[k];
                acc_q[k] <= acc_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[NUM_SEG-1];
    assign sum       = acc_q[NUM_SEG-1];
    assign cout      = c_q[NUM_SEG-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fad_pipe_array.sv
// Self-checking bench for fad_pipe_array: scoreboard of full-precision a+beff+cin results
// plus per-scenario checks of latency, stalls, bubbles and asynchronous reset.
module tb_fad_pipe_array;

    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 8;
    localparam int unsigned LAT = DW / SW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] sum;
    logic          cout;
    logic          ovf;

    int total = 0;
    int bad   = 0;
    int got   = 0;
    logic [DW+1:0] sb [$];   // {cout, sum, ovf}

    fad_pipe_array #(
        .DATA_WIDTH(DW),
        .SEG_WIDTH (SW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Inputs change 1 unit after the rising edge, so the falling edge sees what the next edge will.
    always @(negedge clk) begin : mon
        logic [DW-1:0] be;
        logic [DW:0]   full;
        logic [DW+1:0] exp_v;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got cout=%b sum=%h ovf=%b, required no result", cout, sum, ovf);
                end else begin
                    exp_v = sb.pop_front();
                    got++;
                    if ({cout, sum, ovf} !== exp_v) begin
                        bad++;
                        $display("FAIL sb_result: got cout=%b sum=%h ovf=%b, required cout=%b sum=%h ovf=%b",
                                 cout, sum, ovf, exp_v[DW+1], exp_v[DW:1], exp_v[0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                be   = sub ? ~b : b;
                full = {1'b0, a} + {1'b0, be} + {{DW{1'b0}}, cin};
                sb.push_back({full, (a[DW-1] == be[DW-1]) && (full[DW-1] != a[DW-1])});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_op();
        a   = $urandom;
        b   = $urandom;
        sub = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic sv, input logic cv);
        a = av; b = bv; sub = sv; cin = cv; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                return;
            end
            tick();
        end
        total++; bad++;
        $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required 1");
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) return;
            tick();
        end
        total++; bad++;
        $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got out_valid=%b, required 0", out_valid);
        end
        total++;
        if ({sum, cout, ovf} !== '0) begin
            bad++; $display("FAIL reset_data: got sum=%h cout=%b ovf=%b, required all 0", sum, cout, ovf);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        tick();
    endtask

    task automatic test_carry();
        int lat;
        lat = -1;
        out_ready = 1'b1;
        send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
            tick();
        end
        total++;
        if (lat != int'(LAT) - 1) begin
            bad++; $display("FAIL carry_latency: got %0d edges after acceptance, required %0d", lat, LAT - 1);
        end
        total++;
        if ({sum, cout, ovf} !== {32'h00010000, 1'b0, 1'b0}) begin
            bad++; $display("FAIL carry_value: got sum=%h cout=%b ovf=%b, required sum=00010000 cout=0 ovf=0", sum, cout, ovf);
        end
        tick();
        drain();
    endtask

    task automatic test_wrap_sub();
        logic [DW-1:0] ta [4];
        logic [DW-1:0] tb [4];
        logic          ts [4];
        logic          tc [4];
        logic [DW+1:0] want [4];
        bit            seen;
        ta[0] = 32'hFFFFFFFF; tb[0] = 32'h1; ts[0] = 1'b0; tc[0] = 1'b0; want[0] = {1'b1, 32'h00000000, 1'b0};
        ta[1] = 32'h7FFFFFFF; tb[1] = 32'h1; ts[1] = 1'b0; tc[1] = 1'b0; want[1] = {1'b0, 32'h80000000, 1'b1};
        ta[2] = 32'h00000005; tb[2] = 32'h7; ts[2] = 1'b1; tc[2] = 1'b1; want[2] = {1'b0, 32'hFFFFFFFE, 1'b0};
        ta[3] = 32'h80000000; tb[3] = 32'h1; ts[3] = 1'b1; tc[3] = 1'b1; want[3] = {1'b1, 32'h7FFFFFFF, 1'b1};
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) send(ta[j], tb[j], ts[j], tc[j]);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else tick();
        end
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin
                tick();
                @(negedge clk);
            end
            total++;
            if (!seen || out_valid !== 1'b1 || {cout, sum, ovf} !== want[j]) begin
                bad++;
                $display("FAIL wrap_sub_%0d: got valid=%b cout=%b sum=%h ovf=%b, required valid=1 cout=%b sum=%h ovf=%b",
                         j, out_valid, cout, sum, ovf, want[j][DW+1], want[j][DW:1], want[j][0]);
            end
        end
        tick();
        drain();
    endtask

    task automatic test_backpressure();
        logic [DW+2:0] held;
        bit            stalled_prev;
        int            sent;
        int            base;
        held = '0; stalled_prev = 1'b0; sent = 0; base = got;
        rand_op();
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && sent < 8; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 7);
            @(negedge clk);
            if (!out_ready) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++; $display("FAIL bp_in_ready: got %b during stall, required 0", in_ready);
                end
                if (stalled_prev) begin
                    total++;
                    if ({out_valid, sum, cout, ovf} !== held) begin
                        bad++; $display("FAIL bp_hold: got valid=%b sum=%h, required valid=%b sum=%h",
                                        out_valid, sum, held[DW+2], held[DW+1:2]);
                    end
                end
                held = {out_valid, sum, cout, ovf};
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (in_ready) begin
                sent++;
                tick();
                rand_op();
            end else begin
                tick();
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        total++;
        if (got - base != 8) begin
            bad++; $display("FAIL bp_count: got %0d results, required 8", got - base);
        end
    endtask

    task automatic test_bubbles();
        logic [3:0] pat;
        logic       exp_v;
        pat = 4'b0101;   // in_valid sequence 1,0,1,0 (bit 0 first)
        out_ready = 1'b1;
        for (int cyc = 0; cyc < int'(LAT) + 6; cyc++) begin
            rand_op();
            in_valid = (cyc < 4) ? pat[cyc] : 1'b0;
            @(negedge clk);
            exp_v = (cyc >= int'(LAT) && cyc - int'(LAT) < 4) ? pat[cyc - int'(LAT)] : 1'b0;
            total++;
            if (out_valid !== exp_v) begin
                bad++; $display("FAIL bubble_c%0d: got out_valid=%b, required %b", cyc, out_valid, exp_v);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int sent;
        int base;
        sent = 0; base = got;
        rand_op();
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 300 && sent < 16; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) begin
                sent++;
                tick();
                rand_op();
            end else begin
                tick();
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        total++;
        if (got - base != 16) begin
            bad++; $display("FAIL b2b_count: got %0d results, required 16", got - base);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) send($urandom, $urandom, 1'b0, 1'b1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || sum !== '0) begin
            bad++; $display("FAIL rst_async: got out_valid=%b sum=%h, required 0 and 0", out_valid, sum);
        end
        sb.delete();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_in_ready: got %b, required 1", in_ready);
        end
        tick();
        for (int i = 0; i < int'(LAT) + 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL rst_stale_%0d: got out_valid=%b, required 0", i, out_valid);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_wrap_sub();
        test_backpressure();
        test_bubbles();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

endmodule
